// File: rtl/svc_rv_fetch_q.sv
// Instruction-fetch front end: owns the fetch PC and drives a 1-cycle instruction memory.
// Returned words go into a 2-entry queue whose head is presented to ID.
module svc_rv_fetch_q #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_ren,
  output logic [XLEN-1:0] imem_raddr,
  input  logic [31:0]     imem_rdata,
  input  logic            btb_hit,
  input  logic            btb_taken,
  input  logic [XLEN-1:0] btb_target,
  input  logic            ras_valid,
  input  logic [XLEN-1:0] ras_target,
  input  logic            if_id_stall,
  input  logic [1:0]      pc_sel_id,
  input  logic [XLEN-1:0] pred_target,
  input  logic            redirect_ex,
  input  logic [XLEN-1:0] redirect_target_ex,
  output logic [31:0]     instr_id,
  output logic [XLEN-1:0] pc_id,
  output logic [XLEN-1:0] pc_plus4_id,
  output logic            valid_id,
  output logic            btb_hit_id,
  output logic            btb_pred_taken_id,
  output logic [XLEN-1:0] btb_target_id,
  output logic            ras_valid_id,
  output logic [XLEN-1:0] ras_target_id
);

  localparam logic [31:0] I_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            btb_hit;
    logic            btb_taken;
    logic [XLEN-1:0] btb_target;
    logic            ras_valid;
    logic [XLEN-1:0] ras_target;
  } fetch_tag_t;

  typedef struct packed {
    logic [31:0] instr;
    fetch_tag_t  tag;
  } fq_entry_t;

  logic [XLEN-1:0] pc_if_q, pc_if_d;
  logic [1:0]      count_q, count_d;
  logic            inflight_q, inflight_d;
  fetch_tag_t      tag_q, tag_d;
  fq_entry_t       q_q [2];
  fq_entry_t       q_d [2];

  logic            pop, id_redir, flush, push, issue, push_idx;
  logic [1:0]      occ_after;
  logic [XLEN-1:0] pc_seq;

  assign valid_id = (count_q != 2'd0);

  always_comb begin
    pop       = valid_id && !if_id_stall;
    id_redir  = pop && (pc_sel_id != 2'b00);
    flush     = redirect_ex || id_redir;
    // A redirect drops whatever response is arriving this cycle; no fetch is
    // issued in that cycle because pc_if still holds the wrong-path address.
    push      = inflight_q && !flush;
    occ_after = count_q + {1'b0, inflight_q} - {1'b0, pop};
    issue     = !rst && !flush && (occ_after < 2'd2);
    pc_seq    = (btb_hit && btb_taken) ? btb_target : pc_if_q + XLEN'(4);
  end

  always_comb begin
    pc_if_d = pc_if_q;
    if (redirect_ex)   pc_if_d = redirect_target_ex;
    else if (id_redir) pc_if_d = pred_target;
    else if (issue)    pc_if_d = pc_seq;
  end

  always_comb begin
    inflight_d = issue;
    tag_d      = tag_q;
    if (issue) begin
      tag_d.pc         = pc_if_q;
      tag_d.btb_hit    = btb_hit;
      tag_d.btb_taken  = btb_taken;
      tag_d.btb_target = btb_target;
      tag_d.ras_valid  = ras_valid;
      tag_d.ras_target = ras_target;
    end
  end

  always_comb begin
    q_d[0]   = q_q[0];
    q_d[1]   = q_q[1];
    count_d  = count_q;
    push_idx = pop ? (count_q == 2'd2) : (count_q != 2'd0);
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (pop) q_d[0] = q_q[1];
      if (push) q_d[push_idx] = '{instr: imem_rdata, tag: tag_q};
      count_d = count_q - {1'b0, pop} + {1'b0, push};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_if_q    <= RESET_PC;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      pc_if_q    <= pc_if_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst) q_q[gi] <= '0;
      else     q_q[gi] <= q_d[gi];
    end
  end

  assign imem_ren   = issue;
  assign imem_raddr = pc_if_q;

  assign instr_id          = valid_id ? q_q[0].instr : I_NOP;
  assign pc_id             = valid_id ? q_q[0].tag.pc : '0;
  assign pc_plus4_id       = valid_id ? q_q[0].tag.pc + XLEN'(4) : '0;
  assign btb_hit_id        = valid_id && q_q[0].tag.btb_hit;
  assign btb_pred_taken_id = valid_id && q_q[0].tag.btb_taken;
  assign btb_target_id     = valid_id ? q_q[0].tag.btb_target : '0;
  assign ras_valid_id      = valid_id && q_q[0].tag.ras_valid;
  assign ras_target_id     = valid_id ? q_q[0].tag.ras_target : '0;

endmodule

// File: tb/tb_svc_rv_fetch_q.sv
// Directed bench for svc_rv_fetch_q: a per-cycle vector table for streaming,
// stall and redirects, plus hand sequences for BTB snapshot, PC wrap and reset.
module tb_svc_rv_fetch_q;

  localparam logic [31:0] I_NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ren;
  logic [31:0] imem_raddr;
  logic [31:0] imem_rdata;
  logic        btb_hit, btb_taken;
  logic [31:0] btb_target;
  logic        ras_valid;
  logic [31:0] ras_target;
  logic        if_id_stall;
  logic [1:0]  pc_sel_id;
  logic [31:0] pred_target;
  logic        redirect_ex;
  logic [31:0] redirect_target_ex;
  logic [31:0] instr_id, pc_id, pc_plus4_id;
  logic        valid_id, btb_hit_id, btb_pred_taken_id, ras_valid_id;
  logic [31:0] btb_target_id, ras_target_id;

  logic        btb_en;
  logic [31:0] btb_src, btb_dst;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  svc_rv_fetch_q #(.XLEN(32), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst),
    .imem_ren(imem_ren), .imem_raddr(imem_raddr), .imem_rdata(imem_rdata),
    .btb_hit(btb_hit), .btb_taken(btb_taken), .btb_target(btb_target),
    .ras_valid(ras_valid), .ras_target(ras_target),
    .if_id_stall(if_id_stall), .pc_sel_id(pc_sel_id), .pred_target(pred_target),
    .redirect_ex(redirect_ex), .redirect_target_ex(redirect_target_ex),
    .instr_id(instr_id), .pc_id(pc_id), .pc_plus4_id(pc_plus4_id), .valid_id(valid_id),
    .btb_hit_id(btb_hit_id), .btb_pred_taken_id(btb_pred_taken_id),
    .btb_target_id(btb_target_id), .ras_valid_id(ras_valid_id), .ras_target_id(ras_target_id)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0003;
  endfunction

  // Instruction memory with one cycle of read latency.
  always @(posedge clk) if (imem_ren) imem_rdata <= instr_of(imem_raddr);

  always_comb begin
    btb_hit    = btb_en && (imem_raddr == btb_src);
    btb_taken  = btb_hit;
    btb_target = btb_dst;
  end

  typedef struct packed {
    logic        stall;
    logic [1:0]  sel;
    logic [31:0] pred;
    logic        rex;
    logic [31:0] rtgt;
    logic        ev;
    logic [31:0] epc;
    logic        eren;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(input logic st, input logic [1:0] sl, input logic [31:0] pr,
                              input logic rx, input logic [31:0] rt, input logic ev,
                              input logic [31:0] epc, input logic er, input logic [31:0] ea);
    vec_t v;
    v.stall = st; v.sel = sl; v.pred = pr; v.rex = rx; v.rtgt = rt;
    v.ev = ev; v.epc = epc; v.eren = er; v.eaddr = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic st, input logic [1:0] sl, input logic [31:0] pr,
                       input logic rx, input logic [31:0] rt);
    if_id_stall = st; pc_sel_id = sl; pred_target = pr;
    redirect_ex = rx; redirect_target_ex = rt;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string name, input logic [31:0] epc);
    chk({name, ".valid"}, {31'b0, valid_id}, 32'd1);
    chk({name, ".pc"}, pc_id, epc);
    chk({name, ".instr"}, instr_id, instr_of(epc));
  endtask

  initial begin
    rst = 1'b1;
    btb_en = 1'b0; btb_src = 32'h0; btb_dst = 32'h0;
    ras_valid = 1'b1; ras_target = 32'hDEAD_0000;
    drive(1'b0, 2'd0, 32'h0, 1'b0, 32'h0);
    tick(); tick(); tick();

    // Reset values (RAS inputs are non-zero, outputs must still be 0).
    chk("rst.valid", {31'b0, valid_id}, 32'd0);
    chk("rst.instr", instr_id, I_NOP);
    chk("rst.ren", {31'b0, imem_ren}, 32'd0);
    chk("rst.pc", pc_id, 32'h0);
    chk("rst.pc4", pc_plus4_id, 32'h0);
    chk("rst.snap", {28'b0, btb_hit_id, btb_pred_taken_id, ras_valid_id, 1'b0}, 32'd0);
    chk("rst.tgt", btb_target_id | ras_target_id, 32'h0);

    ras_valid = 1'b0; ras_target = 32'h0;
    rst = 1'b0;

    //            stall sel pred          rex rtgt          ev epc           ren raddr
    tbl[0]  = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h100);
    tbl[1]  = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h104);
    tbl[2]  = mk(1, 0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 32'h0);
    tbl[3]  = mk(1, 0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 32'h0);
    tbl[4]  = mk(1, 0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 32'h0);
    tbl[5]  = mk(1, 0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 32'h0);
    tbl[6]  = mk(1, 0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 32'h0);
    tbl[7]  = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h100, 1, 32'h108);
    tbl[8]  = mk(0, 1, 32'h200, 0, 32'h0,   1, 32'h104, 0, 32'h0);
    tbl[9]  = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h200);
    tbl[10] = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h204);
    tbl[11] = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h200, 1, 32'h208);
    tbl[12] = mk(1, 0, 32'h0,   0, 32'h0,   1, 32'h204, 0, 32'h0);
    tbl[13] = mk(1, 0, 32'h0,   1, 32'h400, 1, 32'h204, 0, 32'h0);
    tbl[14] = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h400);
    tbl[15] = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h404);
    tbl[16] = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h400, 1, 32'h408);
    tbl[17] = mk(1, 0, 32'h0,   1, 32'h500, 1, 32'h404, 0, 32'h0);
    tbl[18] = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h500);
    tbl[19] = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h504);
    tbl[20] = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h500, 1, 32'h508);
    tbl[21] = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h504, 1, 32'h50C);

    for (int i = 0; i < 22; i++) begin
      int f0;
      drive(tbl[i].stall, tbl[i].sel, tbl[i].pred, tbl[i].rex, tbl[i].rtgt);
      f0 = n_total - n_pass;
      chk($sformatf("vec%0d.valid", i), {31'b0, valid_id}, {31'b0, tbl[i].ev});
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d.pc", i), pc_id, tbl[i].epc);
        chk($sformatf("vec%0d.instr", i), instr_id, instr_of(tbl[i].epc));
        chk($sformatf("vec%0d.pc4", i), pc_plus4_id, tbl[i].epc + 32'd4);
      end else begin
        chk($sformatf("vec%0d.nop", i), instr_id, I_NOP);
      end
      chk($sformatf("vec%0d.ren", i), {31'b0, imem_ren}, {31'b0, tbl[i].eren});
      if (tbl[i].eren) chk($sformatf("vec%0d.raddr", i), imem_raddr, tbl[i].eaddr);
      $display("vec %0d stall=%0b sel=%0d rex=%0b -> valid=%0b pc=%h ren=%0b raddr=%h %s",
               i, tbl[i].stall, tbl[i].sel, tbl[i].rex, valid_id, pc_id, imem_ren,
               imem_raddr, (n_total - n_pass == f0) ? "ok" : "bad");
      tick();
    end

    // BTB hit taken at 0x10 -> 0x80; snapshot travels with the 0x10 fetch.
    btb_en = 1'b1; btb_src = 32'h10; btb_dst = 32'h80;
    ras_valid = 1'b1; ras_target = 32'h7700;
    drive(0, 2'd0, 32'h0, 1'b1, 32'h10);
    chk("btb.r.ren", {31'b0, imem_ren}, 32'd0);
    tick();
    drive(0, 2'd0, 32'h0, 1'b0, 32'h0);
    chk("btb.f0", imem_raddr, 32'h10);
    chk("btb.f0.ren", {31'b0, imem_ren}, 32'd1);
    tick();
    chk("btb.f1", imem_raddr, 32'h80);
    chk("btb.f1.valid", {31'b0, valid_id}, 32'd0);
    tick();
    chk_head("btb.h0", 32'h10);
    chk("btb.h0.hit", {31'b0, btb_hit_id}, 32'd1);
    chk("btb.h0.taken", {31'b0, btb_pred_taken_id}, 32'd1);
    chk("btb.h0.tgt", btb_target_id, 32'h80);
    chk("btb.h0.rasv", {31'b0, ras_valid_id}, 32'd1);
    chk("btb.h0.ras", ras_target_id, 32'h7700);
    chk("btb.f2", imem_raddr, 32'h84);
    $display("seq btb head pc=%h taken=%0b tgt=%h", pc_id, btb_pred_taken_id, btb_target_id);
    tick();
    chk_head("btb.h1", 32'h80);
    chk("btb.h1.taken", {31'b0, btb_pred_taken_id}, 32'd0);
    btb_en = 1'b0; ras_valid = 1'b0; ras_target = 32'h0;
    tick();

    // PC wraps from 0xFFFFFFFC to 0.
    drive(0, 2'd0, 32'h0, 1'b1, 32'hFFFF_FFF8);
    tick();
    drive(0, 2'd0, 32'h0, 1'b0, 32'h0);
    chk("wrap.f0", imem_raddr, 32'hFFFF_FFF8);
    tick();
    chk("wrap.f1", imem_raddr, 32'hFFFF_FFFC);
    tick();
    chk("wrap.f2", imem_raddr, 32'h0);
    chk_head("wrap.h0", 32'hFFFF_FFF8);
    tick();
    chk("wrap.f3", imem_raddr, 32'h4);
    chk_head("wrap.h1", 32'hFFFF_FFFC);
    chk("wrap.h1.pc4", pc_plus4_id, 32'h0);
    tick();
    chk_head("wrap.h2", 32'h0);
    $display("seq wrap head pc=%h raddr=%h", pc_id, imem_raddr);
    tick();

    // Reset while a fetch is in flight: its response must never surface.
    rst = 1'b1;
    #2;
    chk("mrst.ren", {31'b0, imem_ren}, 32'd0);
    tick();
    rst = 1'b0;
    #2;
    chk("mrst.c0.valid", {31'b0, valid_id}, 32'd0);
    chk("mrst.c0.nop", instr_id, I_NOP);
    chk("mrst.c0.raddr", imem_raddr, 32'h100);
    chk("mrst.c0.ren", {31'b0, imem_ren}, 32'd1);
    tick();
    chk("mrst.c1.valid", {31'b0, valid_id}, 32'd0);
    chk("mrst.c1.raddr", imem_raddr, 32'h104);
    tick();
    chk_head("mrst.c2", 32'h100);
    $display("seq midreset head pc=%h valid=%0b", pc_id, valid_id);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
